// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the in-place radix-2 DIF FFT sequencer.
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_UNLOAD
    } fft_state_e;

    // Address width / stage count for a given number of points.
    function automatic int fft_log2n(input int num);
        return $clog2(num);
    endfunction

    // Width of the stage index, never narrower than one bit.
    function automatic int fft_stage_w(input int log2n);
        return (log2n <= 2) ? 1 : $clog2(log2n);
    endfunction

    // Reverse the low 'width' bits of 'value'; upper result bits are zero.
    function automatic logic [31:0] fft_bit_rev(input logic [31:0] value, input int width);
        logic [31:0] src;
        logic [31:0] res;
        src = value;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res = {res[30:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Maps (stage, butterfly index) to the two operand addresses and twiddle index
// of an in-place radix-2 DIF FFT. Purely combinational.
module fft_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2N = 4,
    parameter int SW    = 2
) (
    input  logic [SW-1:0]    stage_i,
    input  logic [LOG2N-2:0] k_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] tw_idx_o
);

    localparam logic [LOG2N-1:0] HALF = LOG2N'(1) << (LOG2N - 1);

    logic [LOG2N-1:0] span;
    logic [LOG2N-2:0] mask;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-2:0] grp_bits;

    // span halves every stage; the group bits of k are shifted up one place
    // to skip over the lower half of each group.
    always_comb begin
        span     = HALF >> stage_i;
        mask     = (LOG2N-1)'(span - LOG2N'(1));
        pos      = k_i & mask;
        grp_bits = k_i & ~mask;
        addr_a_o = {grp_bits, 1'b0} | {1'b0, pos};
        addr_b_o = addr_a_o | span;
        tw_idx_o = pos << stage_i;
    end

endmodule

// File: rtl/fft_inplace_sequencer.sv
// Control FSM for a memory-based in-place radix-2 DIF FFT: load, compute
// stages (each followed by a pipeline drain), and bit-reversed unload.
module fft_inplace_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int NUM      = 16,
    parameter int PIPE_LAT = 3,
    localparam int LOG2N   = fft_log2n(NUM),
    localparam int SW      = fft_stage_w(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic             ld_valid,
    output logic             ld_ready,
    output logic [LOG2N-1:0] ld_addr,
    output logic             bf_valid,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [LOG2N-2:0] bf_tw_idx,
    output logic [SW-1:0]    bf_stage,
    output logic             wb_valid,
    output logic [LOG2N-1:0] wb_addr_a,
    output logic [LOG2N-1:0] wb_addr_b,
    output logic             ul_valid,
    input  logic             ul_ready,
    output logic [LOG2N-1:0] ul_addr,
    output logic             done
);

    localparam int KW = LOG2N - 1;
    localparam int DW = $clog2(PIPE_LAT + 1);

    localparam logic [LOG2N-1:0] LAST_PT = LOG2N'(NUM - 1);
    localparam logic [KW-1:0]    LAST_K  = KW'(NUM / 2 - 1);
    localparam logic [SW-1:0]    LAST_S  = SW'(LOG2N - 1);
    localparam logic [DW-1:0]    LAST_D  = DW'(PIPE_LAT - 1);

    fft_state_e       state_q, state_d;
    logic [LOG2N-1:0] ld_cnt_q, ld_cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [LOG2N-1:0] ul_cnt_q, ul_cnt_d;
    logic             done_q, done_d;

    logic             wb_vld_q [PIPE_LAT];
    logic             wb_vld_d [PIPE_LAT];
    logic [LOG2N-1:0] wb_a_q   [PIPE_LAT];
    logic [LOG2N-1:0] wb_a_d   [PIPE_LAT];
    logic [LOG2N-1:0] wb_b_q   [PIPE_LAT];
    logic [LOG2N-1:0] wb_b_d   [PIPE_LAT];

    logic [LOG2N-1:0] map_a;
    logic [LOG2N-1:0] map_b;
    logic [KW-1:0]    map_tw;

    fft_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .stage_i  (stage_q),
        .k_i      (k_q),
        .addr_a_o (map_a),
        .addr_b_o (map_b),
        .tw_idx_o (map_tw)
    );

    // Next-state, counter updates and per-state outputs; idle outputs are 0.
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        k_d       = k_q;
        stage_d   = stage_q;
        drain_d   = drain_q;
        ul_cnt_d  = ul_cnt_q;
        done_d    = 1'b0;
        busy      = (state_q != ST_IDLE);
        ld_ready  = 1'b0;
        ld_addr   = '0;
        bf_valid  = 1'b0;
        bf_addr_a = '0;
        bf_addr_b = '0;
        bf_tw_idx = '0;
        bf_stage  = '0;
        ul_valid  = 1'b0;
        ul_addr   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                ld_addr  = ld_cnt_q;
                if (ld_valid) begin
                    if (ld_cnt_q == LAST_PT) begin
                        ld_cnt_d = '0;
                        k_d      = '0;
                        stage_d  = '0;
                        state_d  = ST_COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LOG2N'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                bf_valid  = 1'b1;
                bf_addr_a = map_a;
                bf_addr_b = map_b;
                bf_tw_idx = map_tw;
                bf_stage  = stage_q;
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                // Hold off the next stage until its inputs have been written back.
                if (drain_q == LAST_D) begin
                    drain_d = '0;
                    if (stage_q == LAST_S) begin
                        stage_d  = '0;
                        ul_cnt_d = '0;
                        state_d  = ST_UNLOAD;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        state_d = ST_COMPUTE;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_UNLOAD: begin
                ul_valid = 1'b1;
                ul_addr  = LOG2N'(fft_bit_rev(32'(ul_cnt_q), LOG2N));
                if (ul_ready) begin
                    if (ul_cnt_q == LAST_PT) begin
                        ul_cnt_d = '0;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        ul_cnt_d = ul_cnt_q + LOG2N'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-back delay line: shifts the issue strobe and addresses every cycle.
    always_comb begin
        wb_vld_d[0] = bf_valid;
        wb_a_d[0]   = bf_addr_a;
        wb_b_d[0]   = bf_addr_b;
        for (int i = 1; i < PIPE_LAT; i++) begin
            wb_vld_d[i] = wb_vld_q[i-1];
            wb_a_d[i]   = wb_a_q[i-1];
            wb_b_d[i]   = wb_b_q[i-1];
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ld_cnt_q <= '0;
            k_q      <= '0;
            stage_q  <= '0;
            drain_q  <= '0;
            ul_cnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            k_q      <= k_d;
            stage_q  <= stage_d;
            drain_q  <= drain_d;
            ul_cnt_q <= ul_cnt_d;
            done_q   <= done_d;
        end
    end

    // Write-back pipe registers; cleared on reset so an abandoned frame leaves no strobes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PIPE_LAT; i++) begin
            if (rst) begin
                wb_vld_q[i] <= 1'b0;
                wb_a_q[i]   <= '0;
                wb_b_q[i]   <= '0;
            end else begin
                wb_vld_q[i] <= wb_vld_d[i];
                wb_a_q[i]   <= wb_a_d[i];
                wb_b_q[i]   <= wb_b_d[i];
            end
        end
    end

    assign wb_valid  = wb_vld_q[PIPE_LAT-1];
    assign wb_addr_a = wb_a_q[PIPE_LAT-1];
    assign wb_addr_b = wb_b_q[PIPE_LAT-1];
    assign done      = done_q;

endmodule

// File: tb/tb_fft_inplace_sequencer.sv
// Directed bench for fft_inplace_sequencer (NUM=16, PIPE_LAT=3) with a
// scoreboard for butterfly issue, write-back and unload order.
module tb_fft_inplace_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       ld_valid;
    logic       ld_ready;
    logic [3:0] ld_addr;
    logic       bf_valid;
    logic [3:0] bf_addr_a;
    logic [3:0] bf_addr_b;
    logic [2:0] bf_tw_idx;
    logic [1:0] bf_stage;
    logic       wb_valid;
    logic [3:0] wb_addr_a;
    logic [3:0] wb_addr_b;
    logic       ul_valid;
    logic       ul_ready;
    logic [3:0] ul_addr;
    logic       done;

    fft_inplace_sequencer #(
        .NUM      (16),
        .PIPE_LAT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .bf_valid  (bf_valid),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .bf_tw_idx (bf_tw_idx),
        .bf_stage  (bf_stage),
        .wb_valid  (wb_valid),
        .wb_addr_a (wb_addr_a),
        .wb_addr_b (wb_addr_b),
        .ul_valid  (ul_valid),
        .ul_ready  (ul_ready),
        .ul_addr   (ul_addr),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] tw;
        logic [1:0] st;
        int         off;
    } bf_exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         due;
    } wb_exp_t;

    bf_exp_t    bf_q[$];
    wb_exp_t    wb_q[$];
    logic [3:0] ul_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = -1;
    int n_wb = 0;
    int n_cd = 0;
    int done_cnt = 0;
    int done_due = -100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic observe();
        bf_exp_t e;
        wb_exp_t w;
        if (bf_valid === 1'b1) begin
            if (bf_q.size() == 0) begin
                chk("bf_unexpected", 32'(bf_valid), 32'(0));
            end else begin
                e = bf_q.pop_front();
                if (t0 < 0) t0 = cyc;
                chk("bf_addr_a", 32'(bf_addr_a), 32'(e.a));
                chk("bf_addr_b", 32'(bf_addr_b), 32'(e.b));
                chk("bf_tw_idx", 32'(bf_tw_idx), 32'(e.tw));
                chk("bf_stage", 32'(bf_stage), 32'(e.st));
                chk("bf_slot", cyc - t0, e.off);
                w.a   = e.a;
                w.b   = e.b;
                w.due = cyc + 3;
                wb_q.push_back(w);
            end
        end
        if (wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'(0));
            end else begin
                w = wb_q.pop_front();
                chk("wb_addr_a", 32'(wb_addr_a), 32'(w.a));
                chk("wb_addr_b", 32'(wb_addr_b), 32'(w.b));
                chk("wb_delay", cyc, w.due);
                n_wb++;
            end
        end else if (wb_q.size() > 0 && wb_q[0].due <= cyc) begin
            chk("wb_missing", 32'(wb_valid), 32'(1));
            w = wb_q.pop_front();
        end
        if (busy === 1'b1 && ld_ready === 1'b0 && ul_valid === 1'b0) n_cd++;
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_cycle", cyc, done_due);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_ld"}, 32'({ld_ready, ld_addr}), 32'(0));
        chk({tag, "_bf"}, 32'({bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage}), 32'(0));
        chk({tag, "_wb"}, 32'({wb_valid, wb_addr_a, wb_addr_b}), 32'(0));
        chk({tag, "_ul"}, 32'({ul_valid, ul_addr}), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    // Queue the expected butterfly schedule of one frame from the span/pos/grp definition.
    task automatic prime_frame();
        bf_exp_t e;
        int span, pos, grp;
        bf_q.delete();
        wb_q.delete();
        ul_q.delete();
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                span  = 16 >> (s + 1);
                pos   = k % span;
                grp   = k / span;
                e.a   = 4'(grp * 2 * span + pos);
                e.b   = 4'(grp * 2 * span + pos + span);
                e.tw  = 3'(pos << s);
                e.st  = 2'(s);
                e.off = s * 11 + k;
                bf_q.push_back(e);
            end
        end
        t0       = -1;
        n_wb     = 0;
        n_cd     = 0;
        done_cnt = 0;
        done_due = -100;
    endtask

    task automatic load_frame(input bit gappy);
        int beats;
        int g;
        bit hs;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'(1));
        beats = 0;
        g = 0;
        while (beats < 16 && g < 100) begin
            ld_valid = gappy ? (g % 2 == 0) : 1'b1;
            chk("ld_ready", 32'(ld_ready), 32'(1));
            chk("ld_addr", 32'(ld_addr), beats);
            hs = ld_valid && ld_ready;
            step();
            if (hs) beats++;
            g++;
        end
        ld_valid = 1'b0;
        chk("load_beats", beats, 16);
        chk("compute_entry", 32'(bf_valid), 32'(1));
        chk("compute_ld_ready", 32'({ld_ready, ld_addr}), 32'(0));
        chk("first_bf_b", 32'(bf_addr_b), 32'(8));
    endtask

    task automatic finish_frame(input bit bp, input bit start_on_done);
        int g;
        int cnt;
        int stall;
        logic [3:0] v;
        logic [3:0] r;
        bit rdy;
        g = 0;
        while (ul_valid !== 1'b1 && g < 100) begin
            start = (g == 5);
            step();
            g++;
        end
        start = 1'b0;
        chk("unload_reached", 32'(ul_valid), 32'(1));
        chk("wb_before_unload", n_wb, 32);
        chk("compute_drain_cycles", n_cd, 44);
        chk("bf_all_issued", bf_q.size(), 0);
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            for (int j = 0; j < 4; j++) r[j] = v[3-j];
            ul_q.push_back(r);
        end
        cnt = 0;
        g = 0;
        stall = 0;
        while (cnt < 16 && g < 200) begin
            chk("ul_valid", 32'(ul_valid), 32'(1));
            chk("ul_addr", 32'(ul_addr), 32'(ul_q[0]));
            rdy = !(bp && cnt == 1 && stall < 4);
            if (!rdy) stall++;
            ul_ready = rdy;
            if (rdy) begin
                r = ul_q.pop_front();
                cnt++;
                if (cnt == 16) done_due = cyc + 1;
            end
            step();
            g++;
        end
        ul_ready = 1'b0;
        chk("unload_count", cnt, 16);
        chk("done_pulse", 32'(done), 32'(1));
        chk("done_idle_busy", 32'(busy), 32'(0));
        start = start_on_done;
        step();
        start = 1'b0;
        chk("done_once", done_cnt, 1);
        chk("done_cleared", 32'(done), 32'(0));
        chk("start_on_done", 32'(ld_ready), 32'(start_on_done));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        ld_valid = 1'b0;
        ul_ready = 1'b0;

        // Reset and idle.
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("idle");
        end

        // Frame with load gaps and unload backpressure.
        prime_frame();
        load_frame(1'b1);
        finish_frame(1'b1, 1'b0);

        // Back-to-back frame, restarted in the done cycle, then reset during LOAD.
        prime_frame();
        load_frame(1'b0);
        finish_frame(1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("load_reset");

        // Reset during stage 2 of COMPUTE.
        prime_frame();
        load_frame(1'b0);
        for (int g = 0; g < 60 && !(bf_valid === 1'b1 && bf_stage == 2'd2); g++) begin
            step();
        end
        chk("reached_stage2", 32'(bf_stage), 32'(2));
        rst = 1'b1;
        bf_q.delete();
        wb_q.delete();
        step();
        rst = 1'b0;
        check_idle("mid_reset");
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle("post_reset");
        end
        chk("no_done_after_reset", done_cnt, 0);

        // Full frame after the abandoned one.
        prime_frame();
        load_frame(1'b1);
        finish_frame(1'b1, 1'b0);
        step();
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
